rx_func_module: RTL and testbench
=================================

# rx_func_module

UART receiver, 8N1, LSB first. It is the receive-side counterpart of the spider_robot serial transmitter. It samples the asynchronous `rxd` line at mid-bit using a fixed clocks-per-bit divider, which defaults to 115200 baud from a 50 MHz `clk`. It delivers each received byte on `oData` with a one-cycle `oDone` pulse. It uses the same `iCall` enable/`oDone` handshake style as the other `*_func_module` blocks.

## Interface
- `BPS`, default 9'd434: clocks per bit; legal range 4..511.
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: asynchronous, active-low reset.
- `iCall`  in  1: receiver enable; while low the block is held in IDLE.
- `rxd`  in  1: asynchronous serial input; idles high.
- `oData`  out  8: last correctly framed byte; holds between frames.
- `oDone`  out  1: one-cycle pulse; `oData` is valid in the same cycle.
- `oErr`  out  1: one-cycle pulse on framing error (stop bit sampled 0).

## Operation
- **Input conditioning:** `rxd` passes through a 2-flop synchronizer. Both flops reset to 1.
  - A third register holds the previous synchronized value.
  - Falling edge = previous 1 and current 0.
- **State machine:** IDLE → START → DATA → STOP → DONE → IDLE. A 9-bit counter `C1` and a 3-bit bit index are used.
  - **IDLE:** `C1`=0. On a falling edge with `iCall`=1, go to START.
  - **START:** count to BPS/2−1 (integer divide), then sample.
    - Sample 0: clear `C1`, go to DATA with index 0.
    - Sample 1: glitch. Return to IDLE with no output pulse.
  - **DATA:** count to BPS−1, then sample into shift register bit [index] (LSB first) and clear `C1`.
    - After index 7, go to STOP.
  - **STOP:** count to BPS−1, then sample.
    - Sample 1: load `oData` from the shift register and assert `oDone`.
    - Sample 0: assert `oErr`; `oData` is unchanged.
    - Either way, go to DONE.
  - **DONE:** deassert `oDone`/`oErr`, go to IDLE.
- **iCall deasserted in any state:** next state IDLE, `C1` cleared, pulses deasserted, `oData` unchanged, partial byte discarded.
- **Line held low:** a line held low continuously, e.g. a break, yields at most one `oErr`. A new frame needs a fresh 1→0 edge after IDLE is re-entered.
- **`oDone` and `oErr`:** never asserted together.

## Timing
- **Reset values:** `oData`=8'h00, `oDone`=0, `oErr`=0, state IDLE, `C1`=0, synchronizer flops 1.
- **Reference point:** let E be the cycle in which the synchronized falling edge is detected. E is 2–3 clk after the physical edge.
- **Sample points:**
  - Start bit sampled at E+BPS/2.
  - Data bit k (k=0..7) sampled at E+BPS/2+(k+1)·BPS.
  - Stop bit sampled at E+BPS/2+9·BPS.
- **Output pulse:** `oDone`/`oErr` is high for exactly the one cycle following the stop sample.
- **Back-to-back frames:** IDLE is reached 2 cycles after the stop sample, i.e. about half a bit before the nominal stop-bit end. Frames with exactly one stop bit are therefore received without loss.
- **Reset mid-frame:** outputs go to reset values immediately (asynchronous). No pulse is produced for the aborted frame.

## Structure
- Shared package/header `uart_params`:
  - `BPS115200`=9'd434 and `BPS9600` (not representable in 9 bits; documented as out of range for this block).
  - The state encoding constants for IDLE/START/DATA/STOP/DONE.
- One sub-module, `rxd_sync_module`: clk, rst_n, rxd → `oRxd` (synchronized), `oFall` (falling-edge pulse).
- The FSM, counter and shift register stay in `rx_func_module`.

## Test plan
1. **Single byte:** `iCall`=1; send 0x55 at BPS=434 → exactly one `oDone`, `oData`=0x55 at E+217+9·434+1; `oErr` stays 0.
2. **Back-to-back frames:** send 0xA3 then 0x0F with a single stop bit and no idle gap → two `oDone` pulses carrying 0xA3 then 0x0F; no `oErr`.
3. **Start-bit glitch:** `rxd` low for 100 cycles, then high → no `oDone`, no `oErr`; a following 0x81 frame is received correctly.
4. **Framing error:** send 0x3C with stop bit forced 0, after a prior good 0x12 → one `oErr` pulse, no `oDone`, `oData` remains 0x12.
5. **Enable abort:** drop `iCall` during data bit 4 of 0xFF, re-raise it, then send 0x7E → no output for the aborted frame; `oDone` with 0x7E.
6. **Reset mid-frame:** assert `rst_n`=0 during bit 2 → `oData`=0x00, `oDone`=0, `oErr`=0 immediately; after release, 0xC9 is received correctly.

Source files
------------

// File: rtl/uart_params_pkg.sv
// Shared UART constants: bit-period dividers for a 50 MHz clock and the receiver state encoding.
package uart_params;

    localparam logic [8:0] BPS115200 = 9'd434;
    // 50 MHz / 9600 needs 13 bits, so it cannot drive the 9-bit divider of rx_func_module.
    localparam int BPS9600 = 5208;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rxd_sync_module.sv
// Two-flop synchronizer for the serial input plus a falling-edge detector on the synchronized line.
module rxd_sync_module (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic oRxd,
    output logic oFall
);

    logic s1;
    logic s2;
    logic prev;

    // All flops reset to the idle-high level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= rxd;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign oRxd  = s2;
    assign oFall = prev & ~s2;

endmodule

// File: rtl/rx_func_module.sv
// 8N1 UART receiver, LSB first, mid-bit sampling with a fixed clocks-per-bit divider.
// Handshake: oDone is a one-cycle pulse with oData valid in that cycle; oErr is a one-cycle framing-error pulse.
module rx_func_module
    import uart_params::*;
#(
    parameter logic [8:0] BPS = BPS115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iCall,
    input  logic       rxd,
    output logic [7:0] oData,
    output logic       oDone,
    output logic       oErr,
    output logic [2:0] dbg_state
);

    localparam logic [8:0] HALF_M1 = (BPS >> 1) - 9'd1;
    localparam logic [8:0] FULL_M1 = BPS - 9'd1;

    logic       rxd_s;
    logic       fall;
    rx_state_t  state;
    logic [8:0] c1;
    logic [2:0] bit_idx;
    logic [7:0] shift;

    rxd_sync_module u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .oRxd  (rxd_s),
        .oFall (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            c1      <= 9'd0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            oData   <= 8'h00;
            oDone   <= 1'b0;
            oErr    <= 1'b0;
        end else if (!iCall) begin
            state <= ST_IDLE;
            c1    <= 9'd0;
            oDone <= 1'b0;
            oErr  <= 1'b0;
        end else begin
            // Pulses are only ever set in STOP, so clearing them every other cycle keeps them one cycle wide.
            oDone <= 1'b0;
            oErr  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    c1 <= 9'd0;
                    if (fall) state <= ST_START;
                end
                ST_START: begin
                    if (c1 == HALF_M1) begin
                        c1      <= 9'd0;
                        bit_idx <= 3'd0;
                        state   <= rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        c1 <= c1 + 9'd1;
                    end
                end
                ST_DATA: begin
                    if (c1 == FULL_M1) begin
                        c1             <= 9'd0;
                        shift[bit_idx] <= rxd_s;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        c1 <= c1 + 9'd1;
                    end
                end
                ST_STOP: begin
                    if (c1 == FULL_M1) begin
                        c1 <= 9'd0;
                        if (rxd_s) begin
                            oData <= shift;
                            oDone <= 1'b1;
                        end else begin
                            oErr <= 1'b1;
                        end
                        state <= ST_DONE;
                    end else begin
                        c1 <= c1 + 9'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rx_func_module.sv
// Directed bench for rx_func_module: serial frames driven bit by bit, received bytes scoreboarded against an expected queue.
module tb_rx_func_module;

    localparam int BPS = 434;

    logic       clk;
    logic       rst_n;
    logic       iCall;
    logic       rxd;
    logic [7:0] oData;
    logic       oDone;
    logic       oErr;
    logic [2:0] dbg_state;

    rx_func_module #(.BPS(9'd434)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iCall     (iCall),
        .rxd       (rxd),
        .oData     (oData),
        .oDone     (oDone),
        .oErr      (oErr),
        .dbg_state (dbg_state)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every output pulse seen on the falling edge
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         err_cnt  = 0;
    int         both_cnt = 0;

    always @(negedge clk) begin
        if (oDone) begin
            got_q.push_back(oData);
            got_cyc.push_back(cyc);
        end
        if (oErr) err_cnt <= err_cnt + 1;
        if (oDone && oErr) both_cnt <= both_cnt + 1;
    end

    // Scoreboard
    logic [7:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int rd         = 0;
    int exp_err    = 0;
    int start_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        check({tag, "_count"}, 32'(got_q.size() - rd), 32'(exp_q.size()));
        while (rd < got_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(got_q[rd]), 32'(e));
            rd++;
        end
        exp_q.delete();
        rd = got_q.size();
    endtask

    // Driver tasks (entered on a falling clock edge)
    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        rxd = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0, BPS);
        for (int i = 0; i < 8; i++) send_bit(d[i], BPS);
        send_bit(stop, BPS);
    endtask

    logic [7:0] byte_c9;
    int         first_idx;

    initial begin
        byte_c9 = 8'hC9;
        rst_n = 1'b0;
        iCall = 1'b0;
        rxd   = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data",  32'(oData), 32'h00);
        check("reset_done",  32'(oDone), 32'h0);
        check("reset_err",   32'(oErr),  32'h0);
        check("reset_state", 32'(dbg_state), 32'h0);
        rst_n = 1'b1;
        idle(5);
        iCall = 1'b1;
        idle(10);

        // Single byte with exact latency: drive at negedge, E is the 3rd posedge, pulse seen 217+9*434 edges later
        first_idx = got_q.size();
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle(20);
        if (got_q.size() > first_idx)
            check("t1_latency", 32'(got_cyc[first_idx] - start_cyc), 32'(3 + BPS / 2 + 9 * BPS));
        else
            check("t1_latency_seen", 32'(got_q.size()), 32'(first_idx + 1));
        drain("t1");
        check("t1_err", 32'(err_cnt), 32'(exp_err));

        // Back-to-back frames, single stop bit, no gap
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(20);
        drain("t2");
        check("t2_err", 32'(err_cnt), 32'(exp_err));

        // Start-bit glitch, then a good frame
        send_bit(1'b0, 100);
        idle(BPS);
        check("t3_glitch_state", 32'(dbg_state), 32'h0);
        drain("t3_glitch");
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(20);
        drain("t3");
        check("t3_err", 32'(err_cnt), 32'(exp_err));

        // Framing error after a good byte
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        idle(20);
        drain("t4_good");
        send_frame(8'h3C, 1'b0);
        exp_err++;
        idle(20);
        drain("t4_bad");
        check("t4_err", 32'(err_cnt), 32'(exp_err));
        check("t4_hold", 32'(oData), 32'h12);

        // Enable drop mid data bit 4 of 0xFF
        send_bit(1'b0, BPS);
        for (int i = 0; i < 4; i++) send_bit(1'b1, BPS);
        send_bit(1'b1, BPS / 2);
        iCall = 1'b0;
        idle(2);
        check("t5_abort_state", 32'(dbg_state), 32'h0);
        idle(8);
        iCall = 1'b1;
        idle(4 * BPS);
        drain("t5_abort");
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(20);
        drain("t5");
        check("t5_err", 32'(err_cnt), 32'(exp_err));

        // Asynchronous reset during data bit 2 of 0xC9
        send_bit(1'b0, BPS);
        send_bit(byte_c9[0], BPS);
        send_bit(byte_c9[1], BPS);
        send_bit(byte_c9[2], 200);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_data", 32'(oData), 32'h00);
        check("t6_rst_done", 32'(oDone), 32'h0);
        check("t6_rst_err",  32'(oErr),  32'h0);
        check("t6_rst_state", 32'(dbg_state), 32'h0);
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        idle(20);
        drain("t6_abort");
        exp_q.push_back(8'hC9);
        send_frame(8'hC9, 1'b1);
        idle(20);
        drain("t6");
        check("t6_err", 32'(err_cnt), 32'(exp_err));

        check("never_both", 32'(both_cnt), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
